sqrt_seq_param: RTL and testbench
=================================

Name: sqrt_seq_param

Overview:
Parametrised sequential integer square-root unit. It is the next generation of the 8-bit start/busy/valid sqrt engine: radicand width is generic, the step rate per clock is selectable, and an abort input is added. It computes root = floor(sqrt(rad)) and rem = rad - root^2 using the restoring digit-by-digit method. It sits behind the same start/busy/valid handshake the bench drivers and monitors already use.

Parameters:
WIDTH, 16, radicand width in bits; even, >= 4. WIDTH=8 reproduces the previous-generation port widths.
STEPS, 1, root bits resolved per clock; 1 or 2. (WIDTH/2) must be divisible by STEPS.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while idle
abort  input  1  cancels an in-flight calculation
rad  input  WIDTH  radicand, captured on the accepted start edge
busy  output  1  calculation in progress
valid  output  1  one-cycle pulse: root/rem are new
root  output  WIDTH/2  floor(sqrt(rad))
rem  output  WIDTH/2+1  rad - root^2 (max 2*root)

Behaviour:
- Reset: while rst=1, outputs are forced asynchronously: busy=0, valid=0, root=0, rem=0, FSM=IDLE, internal registers cleared. Reset mid-calculation discards the operation and produces no valid.
- FSM states:
  - IDLE: on start=1 at edge k, capture rad, clear the partial root and remainder, load N = WIDTH/(2*STEPS), and go to CALC. busy=1 after edge k.
  - CALC: each edge performs STEPS iterations and decrements the counter. After the edge where the counter reaches 0, go to DONE.
  - DONE: lasts exactly one cycle with valid=1 and busy=0, then returns to IDLE.
- Latency: start sampled at edge k gives busy high for cycles k+1 through k+N. At edge k+N+1, root/rem update, valid=1, busy=0. Valid is low from edge k+N+2.
- Back-to-back: start during the DONE cycle is accepted. The next busy rises at the edge that ends DONE, so no idle gap is required.
- Iteration, from the most significant radicand bit pair downward:
  - r = (r<<2) | next pair; t = (q<<2) | 1.
  - If r >= t: r = r - t and q = (q<<1) | 1. Otherwise q = q<<1.
  - Internal r is WIDTH/2+2 bits wide; the final r fits in WIDTH/2+1 bits.
- Output holding: root/rem hold the last completed result until the next completion or reset. They do not change during CALC.
- start while busy: ignored. rad changes while busy: ignored.
- abort=1 in CALC: at that edge go to IDLE with busy=0, no valid pulse, and root/rem keep their previous values.
  - abort in IDLE or DONE has no effect; the valid pulse still occurs.
  - start and abort both high in IDLE: start wins.
- valid and busy are never high in the same cycle.

Test Plan:
- WIDTH=16, STEPS=1: rad=200, start pulse -> busy high for 8 cycles, then valid one cycle with root=14, rem=4.
- Boundaries, WIDTH=16: rad=0 -> 0/0; rad=1 -> 1/0; rad=144 -> 12/0; rad=65535 -> root=255, rem=510.
- Back-to-back: start rad=65535, then start during the DONE cycle with rad=99 -> second valid 9 cycles after the first with root=9, rem=18. A start asserted mid-CALC with rad=4 is ignored (no extra valid).
- Abort and reset: abort at the 3rd busy cycle -> busy=0 next cycle, no valid, root/rem unchanged. Assert rst mid-CALC -> all outputs 0 immediately. After release, start rad=50 -> root=7, rem=1.
- STEPS=2, WIDTH=16: rad=1000 -> busy 4 cycles, root=31, rem=39.
- WIDTH=8, STEPS=1: rad=255 -> busy 4 cycles, root=15, rem=30. Run a random sweep of all 256 radicands against a reference model, checking root^2 + rem == rad and rem <= 2*root.

Source files
------------

// File: rtl/sqrt_seq_param.sv
// Sequential restoring square root: root = floor(sqrt(rad)), rem = rad - root^2, STEPS root bits per clock.
// Latency WIDTH/(2*STEPS) busy cycles then a one-cycle valid; start is ignored while busy, and abort cancels the calculation.
module sqrt_seq_param #(
  parameter int WIDTH = 16,
  parameter int STEPS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     rad,
  output logic                 busy,
  output logic                 valid,
  output logic [WIDTH/2-1:0]   root,
  output logic [WIDTH/2:0]     rem
);

  localparam int H  = WIDTH / 2;
  localparam int N  = WIDTH / (2 * STEPS);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic [H-1:0]     q_q, q_d;
  logic [H+1:0]     r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [H-1:0]     root_q, root_d;
  logic [H:0]       rem_q, rem_d;

  logic [WIDTH-1:0] rad_it;
  logic [H-1:0]     q_it;
  logic [H+1:0]     r_it, t_it;

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;

    // STEPS digit iterations; the radicand register shifts its top pair out each step
    rad_it = rad_q;
    q_it   = q_q;
    r_it   = r_q;
    t_it   = '0;
    for (int i = 0; i < STEPS; i++) begin
      r_it   = {r_it[H-1:0], rad_it[WIDTH-1 -: 2]};
      rad_it = {rad_it[WIDTH-3:0], 2'b00};
      t_it   = {q_it, 2'b01};
      if (r_it >= t_it) begin
        r_it = r_it - t_it;
        q_it = {q_it[H-2:0], 1'b1};
      end else begin
        q_it = {q_it[H-2:0], 1'b0};
      end
    end

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = CALC;
          rad_d   = rad;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CW'(N);
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          rad_d = rad_it;
          q_d   = q_it;
          r_d   = r_it;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            root_d  = q_it;
            rem_d   = r_it[H:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign busy  = (state_q == CALC);
  assign valid = (state_q == DONE);
  assign root  = root_q;
  assign rem   = rem_q;

endmodule

// File: tb/tb_sqrt_seq_param.sv
// Scoreboard bench for sqrt_seq_param: three configurations (16/1, 16/2, 8/1) sharing clock and reset.
module tb_sqrt_seq_param;

  typedef struct packed {
    logic [31:0] rad;
    logic [31:0] root;
    logic [31:0] rem;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 0, a_abort = 0, a_busy, a_valid;
  logic [15:0] a_rad = '0;
  logic [7:0]  a_root;
  logic [8:0]  a_rem;

  logic        b_start = 0, b_abort = 0, b_busy, b_valid;
  logic [15:0] b_rad = '0;
  logic [7:0]  b_root;
  logic [8:0]  b_rem;

  logic        c_start = 0, c_abort = 0, c_busy, c_valid;
  logic [7:0]  c_rad = '0;
  logic [3:0]  c_root;
  logic [4:0]  c_rem;

  sqrt_seq_param #(.WIDTH(16), .STEPS(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .rad(a_rad),
    .busy(a_busy), .valid(a_valid), .root(a_root), .rem(a_rem));
  sqrt_seq_param #(.WIDTH(16), .STEPS(2)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .rad(b_rad),
    .busy(b_busy), .valid(b_valid), .root(b_root), .rem(b_rem));
  sqrt_seq_param #(.WIDTH(8), .STEPS(1)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .rad(c_rad),
    .busy(c_busy), .valid(c_valid), .root(c_root), .rem(c_rem));

  exp_t a_q[$], b_q[$], c_q[$];
  int   n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int isqrt(input int r);
    int x = 0;
    while ((x + 1) * (x + 1) <= r) x++;
    return x;
  endfunction

  function automatic exp_t model(input int r);
    exp_t e;
    e.rad  = r;
    e.root = isqrt(r);
    e.rem  = r - isqrt(r) * isqrt(r);
    return e;
  endfunction

  task automatic score(input string tag, input exp_t e, input int root, input int rem, input bit bsy);
    check({tag, "_root"}, root, e.root);
    check({tag, "_rem"}, rem, e.rem);
    check({tag, "_identity"}, root * root + rem, e.rad);
    check({tag, "_rem_le_2root"}, rem <= 2 * root, 1);
    check({tag, "_busy_with_valid"}, bsy, 0);
  endtask

  always @(negedge clk) if (!rst && a_valid) begin
    if (a_q.size() == 0) check("a_unexpected_valid", 1, 0);
    else score("a", a_q.pop_front(), a_root, a_rem, a_busy);
  end
  always @(negedge clk) if (!rst && b_valid) begin
    if (b_q.size() == 0) check("b_unexpected_valid", 1, 0);
    else score("b", b_q.pop_front(), b_root, b_rem, b_busy);
  end
  always @(negedge clk) if (!rst && c_valid) begin
    if (c_q.size() == 0) check("c_unexpected_valid", 1, 0);
    else score("c", c_q.pop_front(), c_root, c_rem, c_busy);
  end

  function automatic bit bsy(input int d);
    return (d == 0) ? a_busy : (d == 1) ? b_busy : c_busy;
  endfunction
  function automatic bit vld(input int d);
    return (d == 0) ? a_valid : (d == 1) ? b_valid : c_valid;
  endfunction

  task automatic drive(input int d, input bit s, input bit ab, input int r);
    case (d)
      0: begin a_start = s; a_abort = ab; a_rad = 16'(r); end
      1: begin b_start = s; b_abort = ab; b_rad = 16'(r); end
      default: begin c_start = s; c_abort = ab; c_rad = 8'(r); end
    endcase
  endtask

  task automatic enq(input int d, input int r);
    case (d)
      0: a_q.push_back(model(r));
      1: b_q.push_back(model(r));
      default: c_q.push_back(model(r));
    endcase
  endtask

  // One-cycle start pulse; returns 1ns after the accepting edge.
  task automatic go(input int d, input int r, input bit push, input bit ab);
    @(posedge clk); #1;
    drive(d, 1, ab, r);
    if (push) enq(d, r);
    @(posedge clk); #1;
    drive(d, 0, 0, r);
  endtask

  // Returns at the negedge where valid is seen, with the number of busy cycles before it.
  task automatic wait_valid(input int d, input string tag, output int nb);
    bit seen = 0;
    nb = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (vld(d)) seen = 1;
      else if (bsy(d)) nb++;
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nb, cnt, order[256];
    bit seen;

    @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_valid", a_valid, 0);
    check("rst_root", a_root, 0);
    check("rst_rem", a_rem, 0);
    @(posedge clk); #1 rst = 0;

    go(0, 200, 1, 0);
    wait_valid(0, "r200", nb);
    check("r200_busy_cycles", nb, 8);

    // start together with abort in IDLE: start wins
    go(0, 0, 1, 0);   wait_valid(0, "r0", nb);   check("r0_busy_cycles", nb, 8);
    go(0, 1, 1, 1);   wait_valid(0, "r1", nb);   check("r1_busy_cycles", nb, 8);
    go(0, 144, 1, 0); wait_valid(0, "r144", nb); check("r144_busy_cycles", nb, 8);

    // back-to-back: second start issued during the DONE cycle
    go(0, 65535, 1, 0);
    wait_valid(0, "rmax", nb);
    check("rmax_busy_cycles", nb, 8);
    drive(0, 1, 0, 99);
    enq(0, 99);
    @(posedge clk); #1 drive(0, 0, 0, 99);
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cnt++;
      if (cnt == 3) begin
        check("hold_root_during_calc", a_root, 255);
        check("hold_rem_during_calc", a_rem, 510);
        drive(0, 1, 0, 4);
      end
      if (cnt == 4) drive(0, 0, 0, 4);
      if (a_valid) seen = 1;
    end
    check("b2b_seen", seen, 1);
    check("b2b_valid_spacing", cnt, 9);
    idle(20);

    // abort sampled at the edge ending the 3rd busy cycle
    go(0, 200, 0, 0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    a_abort = 1;
    @(posedge clk); #1 a_abort = 0;
    @(negedge clk);
    check("abort_busy", a_busy, 0);
    check("abort_valid", a_valid, 0);
    check("abort_root_kept", a_root, 9);
    check("abort_rem_kept", a_rem, 18);
    idle(15);

    // asynchronous reset mid-calculation
    go(0, 200, 0, 0);
    @(negedge clk); @(negedge clk);
    rst = 1; #1;
    check("arst_busy", a_busy, 0);
    check("arst_valid", a_valid, 0);
    check("arst_root", a_root, 0);
    check("arst_rem", a_rem, 0);
    @(posedge clk); #1 rst = 0;
    idle(12);
    go(0, 50, 1, 0);
    wait_valid(0, "r50", nb);
    check("r50_busy_cycles", nb, 8);

    go(1, 1000, 1, 0);
    wait_valid(1, "s2_r1000", nb);
    check("s2_busy_cycles", nb, 4);

    go(2, 255, 1, 0);
    wait_valid(2, "w8_r255", nb);
    check("w8_busy_cycles", nb, 4);

    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, tmp;
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      go(2, order[i], 1, 0);
      wait_valid(2, "w8_sweep", nb);
    end

    idle(20);
    check("a_queue_drained", a_q.size(), 0);
    check("b_queue_drained", b_q.size(), 0);
    check("c_queue_drained", c_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
